// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC generation, 1-cycle IMEM request
// tracking, and a DEPTH-entry {IR, PC} prefetch FIFO presented to decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    output logic                     IM_REQ,
    output logic [15:0]              IM_ADDR,
    input  logic [31:0]              IM_DATA,
    input  logic                     REDIRECT,
    input  logic [15:0]              REDIRECT_PC,
    input  logic                     DE_READY,
    output logic                     DE_V,
    output logic [31:0]              DE_IR,
    output logic [15:0]              DE_PC,
    output logic [$clog2(DEPTH):0]   Q_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    // Handshake: decode takes the head on any edge where DE_V and DE_READY are
    // both high and REDIRECT is low; DE_READY is ignored while DE_V is low.

    logic [15:0]   f_pc_q, f_pc_d;
    logic          infl_q, infl_d;
    logic [15:0]   infl_pc_q, infl_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   ir_q [DEPTH];
    logic [15:0]   pc_q [DEPTH];

    logic credit_ok;
    logic push;
    logic pop;

    // A request is only issued if its return is guaranteed a free slot.
    assign credit_ok = ({1'b0, count_q} + {{CW{1'b0}}, infl_q}) < DEPTH_C;
    assign IM_REQ    = RST_N & ~REDIRECT & credit_ok;
    assign IM_ADDR   = f_pc_q;
    assign DE_V      = (count_q != '0);
    assign DE_IR     = DE_V ? ir_q[rd_ptr_q] : '0;
    assign DE_PC     = DE_V ? pc_q[rd_ptr_q] : '0;
    assign Q_COUNT   = count_q;
    assign push      = infl_q & ~REDIRECT;
    assign pop       = DE_V & DE_READY & ~REDIRECT;

    always_comb begin
        f_pc_d    = f_pc_q;
        infl_d    = 1'b0;
        infl_pc_d = infl_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (REDIRECT) begin
            f_pc_d   = REDIRECT_PC & 16'hFFFC;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (IM_REQ) begin
                f_pc_d    = f_pc_q + 16'd4;
                infl_d    = 1'b1;
                infl_pc_d = f_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            f_pc_q    <= RESET_PC & 16'hFFFC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            f_pc_q    <= f_pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                ir_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else if (push) begin
            ir_q[wr_ptr_q] <= IM_DATA;
            pc_q[wr_ptr_q] <= infl_pc_q;
        end
    end

    // The credit rule makes this unreachable; firing means the issue logic broke.
    assert property (@(posedge CLK) disable iff (!RST_N)
        !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random DE_READY/REDIRECT
// traffic, checked every cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          CW       = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          IM_REQ;
    logic [15:0]   IM_ADDR;
    logic [31:0]   IM_DATA;
    logic          REDIRECT = 1'b0;
    logic [15:0]   REDIRECT_PC = '0;
    logic          DE_READY = 1'b0;
    logic          DE_V;
    logic [31:0]   DE_IR;
    logic [15:0]   DE_PC;
    logic [CW-1:0] Q_COUNT;

    int tests = 0;
    int fails = 0;

    // reference model: fetch pointer, one in-flight slot, FIFO of PCs
    logic [15:0] m_fpc;
    logic        m_infl;
    logic [15:0] m_inflpc;
    logic [15:0] exp_q[$];

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RST_N(RST_N), .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR),
        .IM_DATA(IM_DATA), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .DE_READY(DE_READY), .DE_V(DE_V), .DE_IR(DE_IR), .DE_PC(DE_PC),
        .Q_COUNT(Q_COUNT)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    function automatic logic [31:0] imem_word(input logic [15:0] a);
        return 32'h1000_0000 + {18'h0, a[15:2]};
    endfunction

    // synchronous instruction memory, 1-cycle read latency
    always @(posedge CLK) IM_DATA <= imem_word(IM_ADDR);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_infl   = 1'b0;
        m_inflpc = '0;
        m_fpc    = RESET_PC & 16'hFFFC;
    endtask

    task automatic model_edge(input logic redir, input logic [15:0] rpc, input logic rdy);
        bit req, pop, push;
        req  = !redir && (exp_q.size() + int'(m_infl) < DEPTH);
        pop  = (exp_q.size() != 0) && rdy && !redir;
        push = m_infl && !redir;
        if (redir) begin
            exp_q.delete();
            m_infl = 1'b0;
            m_fpc  = rpc & 16'hFFFC;
        end else begin
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(m_inflpc);
            if (req) begin
                m_infl   = 1'b1;
                m_inflpc = m_fpc;
                m_fpc    = m_fpc + 16'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        bit          exp_req;
        bit          nonempty;
        logic [15:0] head;
        exp_req  = !REDIRECT && (exp_q.size() + int'(m_infl) < DEPTH);
        nonempty = (exp_q.size() != 0);
        head     = nonempty ? exp_q[0] : 16'h0;
        chk("im_req",  IM_REQ,  exp_req);
        chk("im_addr", IM_ADDR, m_fpc);
        chk("de_v",    DE_V,    nonempty);
        chk("de_pc",   DE_PC,   head);
        chk("de_ir",   DE_IR,   nonempty ? imem_word(head) : 32'h0);
        chk("q_count", Q_COUNT, exp_q.size());
    endtask

    // driver: called just after a falling edge, returns at the next falling edge
    task automatic step(input logic redir, input logic [15:0] rpc, input logic rdy);
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        DE_READY    = rdy;
        #1;
        check_outputs();
        @(posedge CLK);
        model_edge(redir, rpc, rdy);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N    = 1'b0;
        REDIRECT = 1'b0;
        DE_READY = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_im_req",  IM_REQ,  0);
        chk("rst_de_v",    DE_V,    0);
        chk("rst_de_ir",   DE_IR,   0);
        chk("rst_de_pc",   DE_PC,   0);
        chk("rst_q_count", Q_COUNT, 0);
        chk("rst_im_addr", IM_ADDR, RESET_PC & 16'hFFFC);
        RST_N = 1'b1;
    endtask

    initial begin
        model_reset();

        // sequential fetch with decode always ready
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 16'h0, 1'b1);
            if (i == 0) chk("lat_c2_de_v", DE_V, 0);
            if (i == 1) begin
                chk("lat_c3_de_v",  DE_V,  1);
                chk("lat_c3_de_pc", DE_PC, 16'h0000);
                chk("lat_c3_de_ir", DE_IR, 32'h1000_0000);
            end
            chk("tput_qcnt_le1", Q_COUNT <= 1, 1);
        end

        // fill while decode stalls, then redirect with the FIFO full
        do_reset();
        repeat (10) step(1'b0, 16'h0, 1'b0);
        chk("full_q_count", Q_COUNT, DEPTH);
        chk("full_im_req",  IM_REQ,  0);
        chk("full_de_pc",   DE_PC,   16'h0000);
        step(1'b1, 16'h0043, 1'b1);
        chk("redir_c1_q_count", Q_COUNT, 0);
        chk("redir_c1_de_v",    DE_V,    0);
        chk("redir_c1_im_addr", IM_ADDR, 16'h0040);
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("redir_c3_de_v",  DE_V,  1);
        chk("redir_c3_de_pc", DE_PC, 16'h0040);
        repeat (4) step(1'b0, 16'h0, 1'b1);

        // stall then drain: 0,4,8,12 then 16 with no gap
        do_reset();
        repeat (10) step(1'b0, 16'h0, 1'b0);
        repeat (10) step(1'b0, 16'h0, 1'b1);

        // redirect colliding with an in-flight return and a handshake
        do_reset();
        repeat (5) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h0200, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0, 1'b1);
            chk("no_stale_pc", DE_V && (DE_PC < 16'h0200), 0);
        end

        // address wrap at the top of the 16-bit space
        step(1'b1, 16'hFFFE, 1'b1);
        chk("wrap_addr0", IM_ADDR, 16'hFFFC);
        step(1'b0, 16'h0, 1'b1);
        chk("wrap_addr1", IM_ADDR, 16'h0000);
        repeat (6) step(1'b0, 16'h0, 1'b1);

        // asynchronous reset mid-stream with three entries buffered
        do_reset();
        repeat (4) step(1'b0, 16'h0, 1'b0);
        chk("pre_arst_q_count", Q_COUNT, 3);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_de_v",    DE_V,    0);
        chk("arst_im_req",  IM_REQ,  0);
        chk("arst_q_count", Q_COUNT, 0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("arst_refetch_addr", IM_ADDR, RESET_PC & 16'hFFFC);
        repeat (6) step(1'b0, 16'h0, 1'b1);

        // random decode back-pressure and redirects
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic [15:0] t;
            logic        d;
            r = ($urandom_range(0, 19) == 0);
            t = 16'($urandom);
            d = ($urandom_range(0, 3) != 0);
            step(r, t, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
